receptor_deser: RTL

Parametrised successor to the single-bit receptor register. Receives an asynchronous, idle-high serial line (start bit, WIDTH data bits, stop bit) and synchronises it into the CLK domain. It oversamples the line at CLKS_PER_BIT clocks per bit and deserialises the frame into a WIDTH-bit word. The word is presented on a valid/ack holding register, with framing-error and overrun reporting. It sits between the off-chip serial pin and the parallel-word consumers of the shift-register datapath.

---
 rtl/receptor_deser.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/receptor_deser.sv
// Oversampling serial receiver: synchronises an idle-high async line, deserialises
// start/WIDTH data/stop frames and holds the word on a valid/ack register.
module receptor_deser #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter bit          MSB_FIRST    = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic             signal_in,
  input  logic             data_ack,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   line_d_q, line_d_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q, busy_d;

  logic                   line;
  logic                   start_edge;
  logic [WIDTH-1:0]       shifted;

  assign line       = sync_q[SYNC_STAGES-1];
  assign start_edge = line_d_q & ~line;

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

  // Shift register with the sampled bit inserted at the end selected by MSB_FIRST
  always_comb begin
    shifted = shift_q;
    if (MSB_FIRST) begin
      shifted[0] = line;
      for (int i = 1; i < int'(WIDTH); i++) shifted[i] = shift_q[i-1];
    end else begin
      shifted[WIDTH-1] = line;
      for (int i = 0; i < int'(WIDTH) - 1; i++) shifted[i] = shift_q[i+1];
    end
  end

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], signal_in};
    line_d_d = line;
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = ovr_q;

    if (data_ack && valid_q) valid_d = 1'b0;
    if (err_clr) ovr_d = 1'b0;

    if (!enable && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable && start_edge) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = line ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d   = '0;
            shift_d = shifted;
            if (idx_q == IDX_LAST) begin
              state_d = S_STOP;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            if (!line) begin
              ferr_d = 1'b1;
            end else if (!valid_q || data_ack) begin
              // Commit wins over a same-cycle ack, so valid stays high with the new word
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      sync_q   <= '1;
      line_d_q <= 1'b1;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      line_d_q <= line_d_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
    end
  end

endmodule
